// File: rtl/spiflash_pkg.sv
// Shared opcodes, mode constant and FSM state type for the SPI flash responder.
package spiflash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FAST  = 8'h0B;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] CMD_WAKE  = 8'hAB;
  localparam logic [7:0] CMD_RST   = 8'hFF;

  localparam logic [1:0] CRM_EN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_t;

  function automatic logic is_read_cmd(input logic [7:0] op);
    return (op == CMD_READ) || (op == CMD_FAST) || (op == CMD_QREAD);
  endfunction

  function automatic logic is_known_cmd(input logic [7:0] op);
    return is_read_cmd(op) || (op == CMD_WAKE) || (op == CMD_RST);
  endfunction

endpackage

// File: rtl/spiflash_responder_sync.sv
// Two-flop synchroniser for the flash pins plus edge detection on csb and clk.
module spi_in_sync
  import spiflash_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       csb_in,
  input  logic       sclk_in,
  input  logic [3:0] io_in,
  output logic       clk_rise,
  output logic       clk_fall,
  output logic       csb_rise,
  output logic       csb_fall,
  output logic [3:0] io_s
);

  logic [2:0] csb_p;
  logic [2:0] clk_p;
  logic [3:0] io_m;

  // csb history resets to "selected" so a deasserted pin after reset only
  // yields a harmless rise, never a spurious transaction start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csb_p <= '0;
      clk_p <= '0;
      io_m  <= '0;
      io_s  <= '0;
    end else begin
      csb_p <= {csb_p[1:0], csb_in};
      clk_p <= {clk_p[1:0], sclk_in};
      io_m  <= io_in;
      io_s  <= io_m;
    end
  end

  assign clk_rise = clk_p[1] & ~clk_p[2];
  assign clk_fall = ~clk_p[1] & clk_p[2];
  assign csb_rise = csb_p[1] & ~csb_p[2];
  assign csb_fall = ~csb_p[1] & csb_p[2];

endmodule

// File: rtl/spiflash_responder.sv
// QSPI flash emulator: decodes read commands from the SoC flash master and
// serves bytes from a synchronous ROM port on the flash IO lines.
module spiflash_responder
  import spiflash_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DUMMY_FAST = 8,
  parameter int unsigned DUMMY_QUAD = 4
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic [3:0]        flash_io_di,
  output logic [3:0]        flash_io_do,
  output logic [3:0]        flash_io_oeb,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err,
  output logic [7:0]        last_cmd
);

  state_t state, next_state;

  logic              clk_rise, clk_fall, csb_rise, csb_fall;
  logic [3:0]        io_s;
  logic [4:0]        cnt;
  logic [2:0]        bcnt;
  logic              quad;
  logic              crm;
  logic              rd_q;
  logic [7:0]        op;
  logic [6:0]        cmd_sh;
  logic [ADDR_W-2:0] addr_sh;
  logic [7:0]        pre;
  logic [6:0]        sh;

  logic [7:0]        cmd_word;
  logic [ADDR_W-1:0] addr_word;
  logic [4:0]        addr_last;
  logic [4:0]        dummy_last;
  logic [2:0]        byte_last;
  logic              load;
  logic [7:0]        shift_src;

  spi_in_sync u_sync (
    .clk      (core_clk),
    .rstn     (core_rstn),
    .csb_in   (flash_csb),
    .sclk_in  (flash_clk),
    .io_in    (flash_io_di),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .csb_rise (csb_rise),
    .csb_fall (csb_fall),
    .io_s     (io_s)
  );

  // Only the low ADDR_W bits of the flash address are ever kept.
  assign cmd_word   = {cmd_sh, io_s[0]};
  assign addr_word  = quad ? {addr_sh[ADDR_W-5:0], io_s} : {addr_sh, io_s[0]};
  assign addr_last  = quad ? 5'd5 : 5'd23;
  assign dummy_last = quad ? 5'(DUMMY_QUAD - 1) : 5'(DUMMY_FAST - 1);
  assign byte_last  = quad ? 3'd1 : 3'd7;
  assign load       = (bcnt == 3'd0);
  assign shift_src  = load ? pre : (quad ? {sh[3:0], 4'b0000} : {sh, 1'b0});

  always_ff @(posedge core_clk) begin
    if (!core_rstn) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (csb_rise) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (csb_fall) next_state = crm ? ST_ADDR : ST_CMD;
        ST_CMD:
          if (clk_rise && cnt == 5'd7)
            next_state = is_read_cmd(cmd_word) ? ST_ADDR : ST_IGNORE;
        ST_ADDR:
          if (clk_rise && cnt == addr_last) begin
            if (op == CMD_READ)      next_state = ST_DATA;
            else if (op == CMD_FAST) next_state = ST_DUMMY;
            else                     next_state = ST_MODE;
          end
        ST_MODE:
          if (clk_rise && cnt == 5'd1) next_state = ST_DUMMY;
        ST_DUMMY:
          if (clk_rise && cnt == dummy_last) next_state = ST_DATA;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE) && (state != ST_IGNORE);
  end

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      flash_io_do  <= '0;
      flash_io_oeb <= '1;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      cmd_err      <= 1'b0;
      last_cmd     <= '0;
      crm          <= 1'b0;
      cnt          <= '0;
      bcnt         <= '0;
      quad         <= 1'b0;
      rd_q         <= 1'b0;
      op           <= '0;
      cmd_sh       <= '0;
      addr_sh      <= '0;
      pre          <= '0;
      sh           <= '0;
    end else begin
      mem_rd <= 1'b0;
      rd_q   <= mem_rd;
      if (rd_q) pre <= mem_rdata;

      if (next_state != state) cnt <= '0;
      else if (clk_rise)       cnt <= cnt + 5'd1;

      if (csb_rise) begin
        flash_io_oeb <= '1;
        flash_io_do  <= '0;
        // Continuous-read mode survives only a quad transaction that got to data.
        if (!(state == ST_DATA && quad)) crm <= 1'b0;
      end else begin
        case (state)
          ST_IDLE:
            if (csb_fall) begin
              bcnt <= '0;
              if (crm) begin
                quad <= 1'b1;
                op   <= CMD_QREAD;
              end
            end
          ST_CMD:
            if (clk_rise) begin
              cmd_sh <= cmd_word[6:0];
              if (cnt == 5'd7) begin
                last_cmd <= cmd_word;
                op       <= cmd_word;
                quad     <= (cmd_word == CMD_QREAD);
                if (!is_known_cmd(cmd_word)) cmd_err <= 1'b1;
              end
            end
          ST_ADDR:
            if (clk_rise) begin
              addr_sh <= addr_word[ADDR_W-2:0];
              if (cnt == addr_last) begin
                mem_addr <= addr_word;
                mem_rd   <= 1'b1;
              end
            end
          ST_MODE:
            if (clk_rise && cnt == 5'd0) crm <= (io_s[1:0] == CRM_EN);
          ST_DATA:
            if (clk_fall) begin
              sh           <= shift_src[6:0];
              bcnt         <= (bcnt == byte_last) ? 3'd0 : bcnt + 3'd1;
              flash_io_oeb <= quad ? 4'h0 : 4'b1101;
              flash_io_do  <= quad ? shift_src[7:4] : {2'b00, shift_src[7], 1'b0};
              // Each byte load consumes the prefetch and fetches the next byte.
              if (load) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_rd   <= 1'b1;
              end
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spiflash_responder.sv
// Self-checking bench: acts as the flash master and ROM, compares read data
// against a byte-level model of the flash image.
module tb_spiflash_responder;

  localparam int unsigned ADDR_W = 16;

  logic              core_clk = 1'b0;
  logic              core_rstn = 1'b0;
  logic              flash_csb = 1'b1;
  logic              flash_clk = 1'b0;
  logic [3:0]        flash_io_di = '0;
  logic [3:0]        flash_io_do;
  logic [3:0]        flash_io_oeb;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = '0;
  logic              busy;
  logic              cmd_err;
  logic [7:0]        last_cmd;

  int passed = 0;
  int total  = 0;
  int unsigned oeb_errs, busy_errs;
  logic [7:0] got [0:7];
  bit model_crm = 1'b0;

  spiflash_responder #(.ADDR_W(ADDR_W), .DUMMY_FAST(8), .DUMMY_QUAD(4)) dut (
    .core_clk     (core_clk),
    .core_rstn    (core_rstn),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io_di  (flash_io_di),
    .flash_io_do  (flash_io_do),
    .flash_io_oeb (flash_io_oeb),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .cmd_err      (cmd_err),
    .last_cmd     (last_cmd)
  );

  always #5 core_clk = ~core_clk;

  function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Flash image as seen by the master: address truncated, so it aliases.
  function automatic logic [7:0] exp_byte(input logic [23:0] addr, input int unsigned k);
    logic [23:0] a;
    a = addr + 24'(k);
    return rom_byte(a[ADDR_W-1:0]);
  endfunction

  always @(posedge core_clk) if (mem_rd) mem_rdata <= rom_byte(mem_addr);

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic half();
    repeat (6) @(negedge core_clk);
  endtask

  // One SPI clock; outputs are sampled at the end of the low phase, just
  // before the rising edge the master would sample on.
  task automatic sclk(input logic [3:0] drv, input logic [3:0] exp_oeb,
                      input logic exp_busy, output logic [3:0] seen);
    flash_io_di = drv;
    half();
    seen = flash_io_do;
    if (flash_io_oeb !== exp_oeb) oeb_errs++;
    if (busy !== exp_busy) busy_errs++;
    flash_clk = 1'b1;
    half();
    flash_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] s;
    for (int i = 7; i >= 0; i--) sclk({3'b000, b[i]}, 4'hF, 1'b1, s);
  endtask

  task automatic run_read(input logic [7:0] op, input logic [23:0] addr, input logic [7:0] mode,
                          input int unsigned n, input bit skip_cmd);
    logic [3:0] s, s2;
    logic [7:0] acc;
    bit q;
    oeb_errs = 0;
    busy_errs = 0;
    q = (op == 8'hEB);
    flash_csb = 1'b0;
    if (!skip_cmd) send_byte(op);
    if (q) begin
      for (int i = 5; i >= 0; i--) sclk(addr[i*4 +: 4], 4'hF, 1'b1, s);
      sclk(mode[7:4], 4'hF, 1'b1, s);
      sclk(mode[3:0], 4'hF, 1'b1, s);
      for (int i = 0; i < 4; i++) sclk(4'h0, 4'hF, 1'b1, s);
    end else begin
      for (int i = 23; i >= 0; i--) sclk({3'b000, addr[i]}, 4'hF, 1'b1, s);
      if (op == 8'h0B) for (int i = 0; i < 8; i++) sclk(4'h0, 4'hF, 1'b1, s);
    end
    for (int b = 0; b < int'(n); b++) begin
      if (q) begin
        sclk(4'h0, 4'h0, 1'b1, s);
        sclk(4'h0, 4'h0, 1'b1, s2);
        got[b] = {s, s2};
      end else begin
        for (int i = 7; i >= 0; i--) begin
          sclk(4'h0, 4'b1101, 1'b1, s);
          acc[i] = s[1];
        end
        got[b] = acc;
      end
    end
    half();
    flash_csb = 1'b1;
    half();
    if (q) model_crm = (mode[5:4] == 2'b10);
  endtask

  task automatic test_reset();
    core_rstn = 1'b0;
    repeat (5) @(posedge core_clk);
    @(negedge core_clk);
    total++; if (flash_io_do !== 4'h0) $display("FAIL reset_do got=%h exp=0", flash_io_do); else passed++;
    total++; if (flash_io_oeb !== 4'hF) $display("FAIL reset_oeb got=%h exp=f", flash_io_oeb); else passed++;
    total++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); else passed++;
    total++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (cmd_err !== 1'b0) $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL reset_last_cmd got=%h exp=0", last_cmd); else passed++;
    core_rstn = 1'b1;
    repeat (10) @(negedge core_clk);
  endtask

  task automatic test_read_single();
    run_read(8'h03, 24'h000010, 8'h00, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i] !== exp_byte(24'h000010, i))
        $display("FAIL read03_byte%0d got=%h exp=%h", i, got[i], exp_byte(24'h000010, i));
      else passed++;
    end
    total++; if (oeb_errs != 0) $display("FAIL read03_oeb bad_samples=%0d exp=0", oeb_errs); else passed++;
    total++; if (busy_errs != 0) $display("FAIL read03_busy bad_samples=%0d exp=0", busy_errs); else passed++;
    total++; if (last_cmd !== 8'h03) $display("FAIL read03_last_cmd got=%h exp=03", last_cmd); else passed++;
  endtask

  task automatic test_fast_read();
    run_read(8'h0B, 24'h000100, 8'h00, 2, 1'b0);
    total++; if (got[0] !== 8'h5A) $display("FAIL fast_byte0 got=%h exp=5a", got[0]); else passed++;
    total++; if (got[1] !== exp_byte(24'h000100, 1)) $display("FAIL fast_byte1 got=%h exp=%h", got[1], exp_byte(24'h000100, 1)); else passed++;
    total++; if (oeb_errs != 0) $display("FAIL fast_oeb bad_samples=%0d exp=0", oeb_errs); else passed++;
  endtask

  task automatic test_quad_crm();
    run_read(8'hEB, 24'h000020, 8'hA0, 2, 1'b0);
    total++; if (got[0] !== 8'h7A) $display("FAIL quad_byte0 got=%h exp=7a", got[0]); else passed++;
    total++; if (got[1] !== 8'h7B) $display("FAIL quad_byte1 got=%h exp=7b", got[1]); else passed++;
    total++; if (oeb_errs != 0) $display("FAIL quad_oeb bad_samples=%0d exp=0", oeb_errs); else passed++;
    // Continuous read: no opcode, straight to address; mode FF leaves crm.
    run_read(8'hEB, 24'h000000, 8'hFF, 1, 1'b1);
    total++; if (got[0] !== 8'h5A) $display("FAIL crm_byte0 got=%h exp=5a", got[0]); else passed++;
    total++; if (oeb_errs != 0) $display("FAIL crm_oeb bad_samples=%0d exp=0", oeb_errs); else passed++;
  endtask

  task automatic test_bad_opcode();
    logic [3:0] s;
    oeb_errs = 0;
    busy_errs = 0;
    flash_csb = 1'b0;
    send_byte(8'h9F);
    for (int i = 0; i < 16; i++) sclk(4'h0, 4'hF, 1'b0, s);
    half();
    flash_csb = 1'b1;
    half();
    total++; if (cmd_err !== 1'b1) $display("FAIL bad_cmd_err got=%b exp=1", cmd_err); else passed++;
    total++; if (last_cmd !== 8'h9F) $display("FAIL bad_last_cmd got=%h exp=9f", last_cmd); else passed++;
    total++; if (oeb_errs != 0) $display("FAIL bad_oeb bad_samples=%0d exp=0", oeb_errs); else passed++;
    total++; if (busy_errs != 0) $display("FAIL bad_busy bad_samples=%0d exp=0", busy_errs); else passed++;
    run_read(8'h03, 24'h000033, 8'h00, 1, 1'b0);
    total++; if (got[0] !== exp_byte(24'h000033, 0)) $display("FAIL after_bad_byte got=%h exp=%h", got[0], exp_byte(24'h000033, 0)); else passed++;
    total++; if (cmd_err !== 1'b1) $display("FAIL sticky_cmd_err got=%b exp=1", cmd_err); else passed++;
  endtask

  task automatic test_wrap();
    run_read(8'h03, 24'h00FFFF, 8'h00, 2, 1'b0);
    total++; if (got[0] !== 8'hA5) $display("FAIL wrap_byte0 got=%h exp=a5", got[0]); else passed++;
    total++; if (got[1] !== 8'h5A) $display("FAIL wrap_byte1 got=%h exp=5a", got[1]); else passed++;
  endtask

  task automatic test_abort();
    logic [3:0] s;
    logic [23:0] a;
    flash_csb = 1'b0;
    send_byte(8'h03);
    for (int i = 0; i < 12; i++) sclk(4'h1, 4'hF, 1'b1, s);
    flash_csb = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    total++; if (flash_io_oeb !== 4'hF) $display("FAIL abort_oeb got=%h exp=f", flash_io_oeb); else passed++;
    half();
    a = 24'($urandom);
    run_read(8'h03, a, 8'h00, 2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got[i] !== exp_byte(a, i)) $display("FAIL after_abort_byte%0d got=%h exp=%h", i, got[i], exp_byte(a, i));
      else passed++;
    end
  endtask

  task automatic test_reset_mid_data();
    logic [3:0] s;
    flash_csb = 1'b0;
    send_byte(8'h03);
    for (int i = 23; i >= 0; i--) sclk({3'b000, i == 6 ? 1'b1 : 1'b0}, 4'hF, 1'b1, s);
    for (int i = 0; i < 11; i++) sclk(4'h0, 4'b1101, 1'b1, s);
    sclk(4'h0, 4'b1101, 1'b1, s);
    core_rstn = 1'b0;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    total++; if (flash_io_do !== 4'h0) $display("FAIL rstmid_do got=%h exp=0", flash_io_do); else passed++;
    total++; if (flash_io_oeb !== 4'hF) $display("FAIL rstmid_oeb got=%h exp=f", flash_io_oeb); else passed++;
    total++; if (mem_rd !== 1'b0) $display("FAIL rstmid_mem_rd got=%b exp=0", mem_rd); else passed++;
    total++; if (mem_addr !== '0) $display("FAIL rstmid_mem_addr got=%h exp=0", mem_addr); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    total++; if (cmd_err !== 1'b0) $display("FAIL rstmid_cmd_err got=%b exp=0", cmd_err); else passed++;
    total++; if (last_cmd !== 8'h00) $display("FAIL rstmid_last_cmd got=%h exp=0", last_cmd); else passed++;
    core_rstn = 1'b1;
    repeat (10) @(negedge core_clk);
    total++; if (busy !== 1'b0) $display("FAIL rstmid_idle_busy got=%b exp=0", busy); else passed++;
    flash_csb = 1'b1;
    half();
    model_crm = 1'b0;
    run_read(8'h03, 24'h000077, 8'h00, 1, 1'b0);
    total++; if (got[0] !== exp_byte(24'h000077, 0)) $display("FAIL after_rst_byte got=%h exp=%h", got[0], exp_byte(24'h000077, 0)); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] op, mode;
    logic [23:0] a;
    int unsigned n;
    bit skip;
    for (int t = 0; t < 16; t++) begin
      skip = model_crm;
      case ($urandom_range(2))
        0:       op = 8'h03;
        1:       op = 8'h0B;
        default: op = 8'hEB;
      endcase
      if (skip) op = 8'hEB;
      a = 24'($urandom);
      mode = 8'($urandom);
      if ($urandom_range(1) == 1) mode[5:4] = 2'b10;
      n = $urandom_range(4, 1);
      run_read(op, a, mode, n, skip);
      for (int i = 0; i < int'(n); i++) begin
        total++;
        if (got[i] !== exp_byte(a, i))
          $display("FAIL rand%0d_op%h_byte%0d got=%h exp=%h", t, op, i, got[i], exp_byte(a, i));
        else passed++;
      end
      total++;
      if (oeb_errs != 0) $display("FAIL rand%0d_oeb bad_samples=%0d exp=0", t, oeb_errs); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_fast_read();
    test_quad_crm();
    test_bad_opcode();
    test_wrap();
    test_abort();
    test_reset_mid_data();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
